// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shifter: op encodings and FSM states.
package shifter_pkg;

  // Operation encodings carried on in_op.
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// One combinational shift stage: shifts a WIDTH-bit value by 0..STEP
// positions according to the op.
// Optional macro SEQ_SHIFTER_ROTATE_EN: when defined, OP_ROR rotates right;
// when undefined, OP_ROR behaves as SRL and no wrap logic exists.
module shift_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result
);
  import shifter_pkg::*;

`ifdef SEQ_SHIFTER_ROTATE_EN
  // Doubling the word makes a right rotate a plain right shift of the pair.
  logic [2*WIDTH-1:0] rot_wide;
  assign rot_wide = {data, data} >> amt;
`endif

  // Select the shifted value for the current op.
  always_comb begin
    result = data;
    case (op)
      OP_SLL:  result = data << amt;
      OP_SRL:  result = data >> amt;
      OP_SRA:  result = $signed(data) >>> amt;
      default: begin
`ifdef SEQ_SHIFTER_ROTATE_EN
        result = rot_wide[WIDTH-1:0];
`else
        result = data >> amt;
`endif
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter with valid/ready handshakes. Shifts up to STEP bits
// per cycle until the requested amount is consumed, then holds the result
// until the consumer takes it.
// Optional macro SEQ_SHIFTER_ROTATE_EN enables rotate-right for in_op=11
// (otherwise in_op=11 acts as SRL).
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);
  import shifter_pkg::*;

  localparam int AMT_W = $clog2(STEP + 1);
  localparam int REM_W = SHAMT_W + 1;
  localparam logic [REM_W-1:0] STEP_REM = REM_W'(STEP);
  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   data_reg;
  logic [1:0]         op_reg;
  logic [SHAMT_W-1:0] remaining_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic               out_valid_reg;

  logic               accept, advance, finish, out_taken;
  logic [REM_W-1:0]   rem_ext;
  logic               last_step;
  logic [AMT_W-1:0]   step_amt;
  logic [WIDTH-1:0]   step_result;

  // Remaining is widened by one bit so STEP=WIDTH still compares correctly.
  assign rem_ext   = {1'b0, remaining_reg};
  assign last_step = (rem_ext <= STEP_REM);
  assign step_amt  = last_step ? rem_ext[AMT_W-1:0] : STEP_AMT;

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (data_reg),
    .amt    (step_amt),
    .op     (op_reg),
    .result (step_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    out_taken  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (last_step) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_taken  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand, counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg      <= '0;
      op_reg        <= OP_SLL;
      remaining_reg <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        data_reg      <= in_data;
        op_reg        <= in_op;
        remaining_reg <= in_shamt;
      end
      if (advance) begin
        data_reg      <= step_result;
        remaining_reg <= remaining_reg - SHAMT_W'(STEP);
      end
      if (finish) begin
        data_reg      <= step_result;
        remaining_reg <= '0;
        out_data_reg  <= step_result;
        out_valid_reg <= 1'b1;
      end
      if (out_taken) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: drives the same operands into a STEP=1
// and a STEP=4 instance and checks results, latencies, backpressure and
// mid-operation reset. Honours SEQ_SHIFTER_ROTATE_EN for rotate expectations.
module tb_seq_shifter;
  import shifter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_ready;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_data1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .busy(busy1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .busy(busy4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One operation through both instances; hold = cycles of backpressure.
  task automatic run_vec(input string tag, input logic [1:0] op, input logic [31:0] data,
                         input logic [4:0] shamt, input logic [31:0] exp,
                         input int lat1, input int lat4, input int hold);
    int c1 = 0;
    int c4 = 0;
    logic [31:0] r1 = '0;
    logic [31:0] r4 = '0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_shamt = shamt;
    in_op    = op;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq({tag, "_busy1"}, 32'(busy1), 32'd1);
    check_eq({tag, "_rdy4"}, 32'(in_ready4), 32'd0);
    for (int n = 1; n <= 40 && (c1 == 0 || c4 == 0); n++) begin
      @(posedge clk);
      #1;
      if (out_valid1 && c1 == 0) begin c1 = n; r1 = out_data1; end
      if (out_valid4 && c4 == 0) begin c4 = n; r4 = out_data4; end
    end
    check_eq({tag, "_lat1"}, 32'(c1), 32'(lat1));
    check_eq({tag, "_dat1"}, r1, exp);
    check_eq({tag, "_lat4"}, 32'(c4), 32'(lat4));
    check_eq({tag, "_dat4"}, r4, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = ~data;
      @(posedge clk);
      #1;
      check_eq($sformatf("%s_hold%0d_v", tag, h), 32'(out_valid1), 32'd1);
      check_eq($sformatf("%s_hold%0d_d", tag, h), out_data1, r1);
      check_eq($sformatf("%s_hold%0d_r", tag, h), 32'(in_ready1), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_drop1"}, 32'(out_valid1), 32'd0);
    check_eq({tag, "_idle1"}, 32'(in_ready1), 32'd1);
    check_eq({tag, "_drop4"}, 32'(out_valid4), 32'd0);
    check_eq({tag, "_idle4"}, 32'(in_ready4), 32'd1);
    $display("txn %s op=%0d data=%h shamt=%0d -> s1 %h@%0d s4 %h@%0d", tag, op, data, shamt, r1, c1, r4, c4);
  endtask

  logic [31:0] ror_f_exp;
  logic [31:0] ror_b_exp;
  logic        late;

  initial begin
`ifdef SEQ_SHIFTER_ROTATE_EN
    ror_f_exp = 32'hF000_0000;
    ror_b_exp = 32'h7812_3456;
`else
    ror_f_exp = 32'h0000_0000;
    ror_b_exp = 32'h0012_3456;
`endif
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = OP_SLL;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(in_ready1), 32'd1);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_valid", 32'(out_valid1), 32'd0);
    check_eq("rst_data", out_data1, 32'd0);
    rst_n = 1'b1;

    run_vec("sra4",    OP_SRA, 32'h8000_00F0, 5'd4,  32'hF800_000F, 4,  1, 5);
    run_vec("sll31",   OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 31, 8, 0);
    run_vec("zero_sll", OP_SLL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1,  1, 0);
    run_vec("zero_srl", OP_SRL, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1,  1, 0);
    run_vec("zero_sra", OP_SRA, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1,  1, 0);
    run_vec("zero_ror", OP_ROR, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1,  1, 0);
    run_vec("ror4",    OP_ROR, 32'h0000_000F, 5'd4,  ror_f_exp,     4,  1, 0);
    run_vec("ror8",    OP_ROR, 32'h1234_5678, 5'd8,  ror_b_exp,     8,  2, 0);
    run_vec("srl8",    OP_SRL, 32'hF000_0000, 5'd8,  32'h00F0_0000, 8,  2, 0);
    run_vec("srl3",    OP_SRL, 32'h8000_0000, 5'd3,  32'h1000_0000, 3,  1, 0);
    run_vec("sra31",   OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 31, 8, 0);
    run_vec("sra16",   OP_SRA, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF, 16, 4, 0);
    run_vec("sll5",    OP_SLL, 32'h0000_00FF, 5'd5,  32'h0000_1FE0, 5,  2, 0);

    // Reset while a long SRL is in flight.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    in_shamt = 5'd20;
    in_op    = OP_SRL;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mrst_valid1", 32'(out_valid1), 32'd0);
    check_eq("mrst_data1", out_data1, 32'd0);
    check_eq("mrst_ready1", 32'(in_ready1), 32'd1);
    check_eq("mrst_busy1", 32'(busy1), 32'd0);
    check_eq("mrst_valid4", 32'(out_valid4), 32'd0);
    check_eq("mrst_ready4", 32'(in_ready4), 32'd1);
    rst_n = 1'b1;
    late = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid1 || out_valid4 || busy1 || busy4) late = 1'b1;
    end
    check_eq("mrst_no_late", 32'(late), 32'd0);
    $display("txn mid_reset srl shamt=20 -> discarded");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
